data_bus_arbiter: RTL and testbench
===================================

// Module: data_bus_arbiter
// PURPOSE
//  Shares the single data-memory bus between two masters: M0 = riscv_core, M1 = a peripheral/DMA master.
//  Round-robin arbitration; one transaction in flight at a time.
//  Latches the winner's command and drives it as one registered bus access.
//  Returns read data to the owning master with a done pulse.
// PARAMETERS
//  READ_LATENCY  1  cycles from the bus_read_enable cycle to bus_data_fetched valid; legal range 1..15
// PORTS
//  clock              in   1   system clock; all state changes on the rising edge
//  reset              in   1   synchronous, active-high
//  mN_request         in   1   N=0,1: transaction request; held until mN_done
//  mN_write           in   1   1 = write, 0 = read
//  mN_address         in   32  byte address
//  mN_write_data      in   32  store data
//  mN_format          in   3   funct3 width/sign code, passed through unchanged
//  mN_grant           out  1   one-cycle pulse: mN's command was latched
//  mN_done            out  1   one-cycle pulse: transaction complete
//  mN_data_fetched    out  32  read result; valid while mN_done=1, then held
//  bus_address        out  32  registered command to the memory bus
//  bus_write_data     out  32
//  bus_format         out  3
//  bus_read_enable    out  1
//  bus_write_enable   out  1
//  bus_data_fetched   in   32  read data from the bus
//  busy               out  1   high in any state except IDLE
// BEHAVIOUR
//  Reset: every output is 0, state=IDLE, wait counter=0, last_grant=1 (so M0 wins the first tie).
//  FSM states: IDLE, ACCESS, WAIT, DONE.
//  - IDLE:
//    - No request -> stay in IDLE.
//    - Exactly one request -> that master wins.
//    - Both requesting -> grant the master that is not last_grant.
//    - On a win (edge ending IDLE cycle t): latch the winner's address/write_data/format/write into the bus_* registers,
//      set last_grant, move to ACCESS.
//  - ACCESS (cycle t+1):
//    - mN_grant=1 for the winner.
//    - Exactly one of bus_write_enable / bus_read_enable is high, per the latched write bit.
//    - Write -> DONE.
//    - Read -> WAIT, with the counter loaded to READ_LATENCY-1.
//  - WAIT (cycles t+2 .. t+1+READ_LATENCY):
//    - Both enables low; decrement the counter each cycle.
//    - When the counter is 0: capture bus_data_fetched into the owner's mN_data_fetched and go to DONE.
//  - DONE:
//    - Owner's mN_done=1 for exactly one cycle, then IDLE.
//    - The requester must deassert mN_request by the IDLE cycle that follows DONE.
//      A request still high in IDLE is treated as a new transaction.
//  Latency, from the request-sampled cycle t:
//  - write: done at t+2
//  - read: done at t+2+READ_LATENCY
//  - idle turnaround: 1 cycle
//  bus_address / bus_write_data / bus_format stay stable from ACCESS until the next latch; they are not cleared.
//  The non-owner's mN_data_fetched is never modified. mN_done and mN_grant are never both high for M0 and M1.
//  A request dropped mid-transaction is ignored; the transaction still completes and pulses done.
//  Request changes while the block is not in IDLE are ignored; the command fields are sampled only in IDLE.
//  Reset in any state: the next cycle is IDLE with all outputs 0. No done pulse is issued for the aborted transaction.
//  Fairness: a continuously requesting master cannot win twice in a row while the other is requesting.
//  The worst-case wait for a master is one foreign transaction.
// TESTING
//  1) Hold reset 3 cycles with both requests high.
//     -> all outputs 0 and busy=0 throughout; M0 is granted first after release.
//  2) M0 write only: addr=0x10010000, data=0xDEADBEEF, format=3'b010.
//     -> bus_write_enable high exactly 1 cycle with those values; m0_done at t+2; all m1_* outputs stay 0.
//  3) READ_LATENCY=2; M1 read of addr 0x0000FF00; the slave model drives 0x12345678 two cycles after the enable.
//     -> m1_data_fetched=0x12345678 with m1_done at t+4.
//  4) Both masters request continuously, 4 transactions each.
//     -> grants alternate M0,M1,M0,M1,...; no double grant.
//  5) During an M0 read, M1 raises its request.
//     -> M1 is granted in the ACCESS cycle right after M0's DONE plus one IDLE; M0's data is unaffected.
//  6) Assert reset during WAIT (READ_LATENCY=4).
//     -> no m0_done; the next cycle has enables=0, busy=0 and bus_address=0.

Source files
------------

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter for the data-memory bus.
// Only one transaction is in flight at a time. Every output comes straight from a register.
module data_bus_arbiter #(
   parameter int READ_LATENCY = 1  // legal range 1..15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        m0_request,
   input  logic        m0_write,
   input  logic [31:0] m0_address,
   input  logic [31:0] m0_write_data,
   input  logic [2:0]  m0_format,
   output logic        m0_grant,
   output logic        m0_done,
   output logic [31:0] m0_data_fetched,
   input  logic        m1_request,
   input  logic        m1_write,
   input  logic [31:0] m1_address,
   input  logic [31:0] m1_write_data,
   input  logic [2:0]  m1_format,
   output logic        m1_grant,
   output logic        m1_done,
   output logic [31:0] m1_data_fetched,
   output logic [31:0] bus_address,
   output logic [31:0] bus_write_data,
   output logic [2:0]  bus_format,
   output logic        bus_read_enable,
   output logic        bus_write_enable,
   input  logic [31:0] bus_data_fetched,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(READ_LATENCY - 1);

   state_t      state_r, state_s;
   logic [3:0]  wait_count_r, wait_count_s;
   logic        last_grant_r, last_grant_s;
   logic        owner_r, owner_s;
   logic        cmd_write_r, cmd_write_s;
   logic        any_request_s;
   logic        winner_s;
   logic        sel_write_s;
   logic [31:0] sel_address_s;
   logic [31:0] sel_write_data_s;
   logic [2:0]  sel_format_s;

   logic        m0_grant_r, m0_grant_s;
   logic        m1_grant_r, m1_grant_s;
   logic        m0_done_r, m0_done_s;
   logic        m1_done_r, m1_done_s;
   logic [31:0] m0_data_r, m0_data_s;
   logic [31:0] m1_data_r, m1_data_s;
   logic [31:0] bus_address_r, bus_address_s;
   logic [31:0] bus_write_data_r, bus_write_data_s;
   logic [2:0]  bus_format_r, bus_format_s;
   logic        bus_read_enable_r, bus_read_enable_s;
   logic        bus_write_enable_r, bus_write_enable_s;
   logic        busy_r, busy_s;

   // State register and all registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r            <= ST_IDLE;
         wait_count_r       <= 4'd0;
         last_grant_r       <= 1'b1;
         owner_r            <= 1'b0;
         cmd_write_r        <= 1'b0;
         m0_grant_r         <= 1'b0;
         m1_grant_r         <= 1'b0;
         m0_done_r          <= 1'b0;
         m1_done_r          <= 1'b0;
         m0_data_r          <= 32'd0;
         m1_data_r          <= 32'd0;
         bus_address_r      <= 32'd0;
         bus_write_data_r   <= 32'd0;
         bus_format_r       <= 3'd0;
         bus_read_enable_r  <= 1'b0;
         bus_write_enable_r <= 1'b0;
         busy_r             <= 1'b0;
      end else begin
         state_r            <= state_s;
         wait_count_r       <= wait_count_s;
         last_grant_r       <= last_grant_s;
         owner_r            <= owner_s;
         cmd_write_r        <= cmd_write_s;
         m0_grant_r         <= m0_grant_s;
         m1_grant_r         <= m1_grant_s;
         m0_done_r          <= m0_done_s;
         m1_done_r          <= m1_done_s;
         m0_data_r          <= m0_data_s;
         m1_data_r          <= m1_data_s;
         bus_address_r      <= bus_address_s;
         bus_write_data_r   <= bus_write_data_s;
         bus_format_r       <= bus_format_s;
         bus_read_enable_r  <= bus_read_enable_s;
         bus_write_enable_r <= bus_write_enable_s;
         busy_r             <= busy_s;
      end
   end

   // Winner selection: on a tie the master that did not win last time goes first
   always_comb begin
      any_request_s = m0_request || m1_request;
      if (m0_request && m1_request) begin
         winner_s = ~last_grant_r;
      end else if (m1_request) begin
         winner_s = 1'b1;
      end else begin
         winner_s = 1'b0;
      end
      if (winner_s) begin
         sel_write_s      = m1_write;
         sel_address_s    = m1_address;
         sel_write_data_s = m1_write_data;
         sel_format_s     = m1_format;
      end else begin
         sel_write_s      = m0_write;
         sel_address_s    = m0_address;
         sel_write_data_s = m0_write_data;
         sel_format_s     = m0_format;
      end
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (any_request_s) begin
               state_s = ST_ACCESS;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (cmd_write_r) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (wait_count_r == 4'd0) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_DONE: state_s = ST_IDLE;
         default: state_s = ST_IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs; pulses default low, data holds
   always_comb begin
      wait_count_s       = wait_count_r;
      last_grant_s       = last_grant_r;
      owner_s            = owner_r;
      cmd_write_s        = cmd_write_r;
      m0_grant_s         = 1'b0;
      m1_grant_s         = 1'b0;
      m0_done_s          = 1'b0;
      m1_done_s          = 1'b0;
      m0_data_s          = m0_data_r;
      m1_data_s          = m1_data_r;
      bus_address_s      = bus_address_r;
      bus_write_data_s   = bus_write_data_r;
      bus_format_s       = bus_format_r;
      bus_read_enable_s  = 1'b0;
      bus_write_enable_s = 1'b0;
      busy_s             = (state_s != ST_IDLE);
      case (state_r)
         ST_IDLE: begin
            if (any_request_s) begin
               owner_s            = winner_s;
               last_grant_s       = winner_s;
               cmd_write_s        = sel_write_s;
               bus_address_s      = sel_address_s;
               bus_write_data_s   = sel_write_data_s;
               bus_format_s       = sel_format_s;
               bus_write_enable_s = sel_write_s;
               bus_read_enable_s  = ~sel_write_s;
               m0_grant_s         = ~winner_s;
               m1_grant_s         = winner_s;
            end else begin
               wait_count_s = 4'd0;
            end
         end
         ST_ACCESS: begin
            if (cmd_write_r) begin
               m0_done_s = ~owner_r;
               m1_done_s = owner_r;
            end else begin
               wait_count_s = WAIT_INIT;
            end
         end
         ST_WAIT: begin
            if (wait_count_r == 4'd0) begin
               m0_done_s = ~owner_r;
               m1_done_s = owner_r;
               if (owner_r) begin
                  m1_data_s = bus_data_fetched;
               end else begin
                  m0_data_s = bus_data_fetched;
               end
            end else begin
               wait_count_s = wait_count_r - 4'd1;
            end
         end
         ST_DONE: wait_count_s = 4'd0;
         default: wait_count_s = 4'd0;
      endcase
   end

   assign m0_grant         = m0_grant_r;
   assign m1_grant         = m1_grant_r;
   assign m0_done          = m0_done_r;
   assign m1_done          = m1_done_r;
   assign m0_data_fetched  = m0_data_r;
   assign m1_data_fetched  = m1_data_r;
   assign bus_address      = bus_address_r;
   assign bus_write_data   = bus_write_data_r;
   assign bus_format       = bus_format_r;
   assign bus_read_enable  = bus_read_enable_r;
   assign bus_write_enable = bus_write_enable_r;
   assign busy             = busy_r;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: instance A runs with READ_LATENCY=2.
// Instance B runs with READ_LATENCY=4 and is used for the reset-during-WAIT case.
module tb_data_bus_arbiter;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   // instance A (READ_LATENCY = 2)
   logic        reset;
   logic        m0_request, m0_write, m1_request, m1_write;
   logic [31:0] m0_address, m0_write_data, m1_address, m1_write_data;
   logic [2:0]  m0_format, m1_format;
   logic        m0_grant, m0_done, m1_grant, m1_done;
   logic [31:0] m0_data_fetched, m1_data_fetched;
   logic [31:0] bus_address, bus_write_data, bus_data_fetched;
   logic [2:0]  bus_format;
   logic        bus_read_enable, bus_write_enable, busy;

   // instance B (READ_LATENCY = 4)
   logic        b_reset;
   logic        b_m0_request, b_m0_write, b_m1_request, b_m1_write;
   logic [31:0] b_m0_address, b_m0_write_data, b_m1_address, b_m1_write_data;
   logic [2:0]  b_m0_format, b_m1_format;
   logic        b_m0_grant, b_m0_done, b_m1_grant, b_m1_done;
   logic [31:0] b_m0_data_fetched, b_m1_data_fetched;
   logic [31:0] b_bus_address, b_bus_write_data, b_bus_data_fetched;
   logic [2:0]  b_bus_format;
   logic        b_bus_read_enable, b_bus_write_enable, b_busy;

   logic [31:0] slave_data_a, slave_data_b;
   logic [1:0]  rd_pipe_a = 2'b00;
   logic [3:0]  rd_pipe_b = 4'b0000;

   int n_checks = 0;
   int n_errors = 0;

   data_bus_arbiter #(.READ_LATENCY(2)) dut_a (
      .clock(clock), .reset(reset),
      .m0_request(m0_request), .m0_write(m0_write), .m0_address(m0_address),
      .m0_write_data(m0_write_data), .m0_format(m0_format),
      .m0_grant(m0_grant), .m0_done(m0_done), .m0_data_fetched(m0_data_fetched),
      .m1_request(m1_request), .m1_write(m1_write), .m1_address(m1_address),
      .m1_write_data(m1_write_data), .m1_format(m1_format),
      .m1_grant(m1_grant), .m1_done(m1_done), .m1_data_fetched(m1_data_fetched),
      .bus_address(bus_address), .bus_write_data(bus_write_data), .bus_format(bus_format),
      .bus_read_enable(bus_read_enable), .bus_write_enable(bus_write_enable),
      .bus_data_fetched(bus_data_fetched), .busy(busy)
   );

   data_bus_arbiter #(.READ_LATENCY(4)) dut_b (
      .clock(clock), .reset(b_reset),
      .m0_request(b_m0_request), .m0_write(b_m0_write), .m0_address(b_m0_address),
      .m0_write_data(b_m0_write_data), .m0_format(b_m0_format),
      .m0_grant(b_m0_grant), .m0_done(b_m0_done), .m0_data_fetched(b_m0_data_fetched),
      .m1_request(b_m1_request), .m1_write(b_m1_write), .m1_address(b_m1_address),
      .m1_write_data(b_m1_write_data), .m1_format(b_m1_format),
      .m1_grant(b_m1_grant), .m1_done(b_m1_done), .m1_data_fetched(b_m1_data_fetched),
      .bus_address(b_bus_address), .bus_write_data(b_bus_write_data), .bus_format(b_bus_format),
      .bus_read_enable(b_bus_read_enable), .bus_write_enable(b_bus_write_enable),
      .bus_data_fetched(b_bus_data_fetched), .busy(b_busy)
   );

   // slave model: read data is valid exactly READ_LATENCY cycles after the enable cycle
   always @(posedge clock) begin
      rd_pipe_a <= {rd_pipe_a[0], bus_read_enable};
      rd_pipe_b <= {rd_pipe_b[2:0], b_bus_read_enable};
   end
   assign bus_data_fetched   = rd_pipe_a[1] ? slave_data_a : 32'h0;
   assign b_bus_data_fetched = rd_pipe_b[3] ? slave_data_b : 32'h0;

   logic any_out_a, any_out_b;
   assign any_out_a = |{m0_grant, m0_done, m0_data_fetched, m1_grant, m1_done, m1_data_fetched,
                        bus_address, bus_write_data, bus_format, bus_read_enable, bus_write_enable, busy};
   assign any_out_b = |{b_m0_grant, b_m0_done, b_m0_data_fetched, b_m1_grant, b_m1_done,
                        b_m1_data_fetched, b_bus_address, b_bus_write_data, b_bus_format,
                        b_bus_read_enable, b_bus_write_enable, b_busy};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int grants;
      logic exp_m1;

      reset = 1'b1;  b_reset = 1'b1;
      m0_request = 1'b1; m0_write = 1'b1; m0_address = 32'h4; m0_write_data = 32'h1; m0_format = 3'd2;
      m1_request = 1'b1; m1_write = 1'b1; m1_address = 32'h8; m1_write_data = 32'h2; m1_format = 3'd2;
      b_m0_request = 1'b0; b_m0_write = 1'b0; b_m0_address = 32'h0; b_m0_write_data = 32'h0; b_m0_format = 3'd0;
      b_m1_request = 1'b0; b_m1_write = 1'b0; b_m1_address = 32'h0; b_m1_write_data = 32'h0; b_m1_format = 3'd0;
      slave_data_a = 32'h0; slave_data_b = 32'h0;

      // 1) reset held 3 cycles with both requests high
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reset_outputs_zero", {31'd0, any_out_a}, 32'd0);
         check("reset_busy", {31'd0, busy}, 32'd0);
      end
      reset = 1'b0; b_reset = 1'b0;
      tick();
      check("first_grant_m0", {30'd0, m1_grant, m0_grant}, 32'b01);
      m0_request = 1'b0; m1_request = 1'b0;
      tick();
      check("first_done_m0", {30'd0, m1_done, m0_done}, 32'b01);
      tick();
      check("first_back_idle", {31'd0, busy}, 32'd0);

      // 2) M0 write
      m0_request = 1'b1; m0_write = 1'b1; m0_address = 32'h1001_0000;
      m0_write_data = 32'hDEAD_BEEF; m0_format = 3'b010;
      tick();
      check("wr_grant", {30'd0, m1_grant, m0_grant}, 32'b01);
      check("wr_enables", {30'd0, bus_write_enable, bus_read_enable}, 32'b10);
      check("wr_address", bus_address, 32'h1001_0000);
      check("wr_data", bus_write_data, 32'hDEAD_BEEF);
      check("wr_format", {29'd0, bus_format}, 32'd2);
      check("wr_busy", {31'd0, busy}, 32'd1);
      m0_request = 1'b0;
      tick();
      check("wr_done_t2", {30'd0, m1_done, m0_done}, 32'b01);
      check("wr_enable_one_cycle", {30'd0, bus_write_enable, bus_read_enable}, 32'b00);
      check("wr_m1_quiet", {m1_data_fetched[29:0], m1_grant, m1_done}, 32'd0);
      tick();
      check("wr_done_pulse", {31'd0, m0_done}, 32'd0);
      check("wr_idle_busy", {31'd0, busy}, 32'd0);

      // 3) M1 read with READ_LATENCY=2
      slave_data_a = 32'h1234_5678;
      m1_request = 1'b1; m1_write = 1'b0; m1_address = 32'h0000_FF00;
      tick();
      check("rd_grant", {30'd0, m1_grant, m0_grant}, 32'b10);
      check("rd_enables", {30'd0, bus_write_enable, bus_read_enable}, 32'b01);
      check("rd_address", bus_address, 32'h0000_FF00);
      m1_request = 1'b0;
      tick();
      check("rd_wait1", {29'd0, bus_read_enable, m1_done, m0_done}, 32'd0);
      tick();
      check("rd_wait2", {29'd0, bus_read_enable, m1_done, m0_done}, 32'd0);
      tick();
      check("rd_done_t4", {30'd0, m1_done, m0_done}, 32'b10);
      check("rd_data", m1_data_fetched, 32'h1234_5678);
      check("rd_m0_data_untouched", m0_data_fetched, 32'd0);
      tick();
      check("rd_data_held", m1_data_fetched, 32'h1234_5678);
      check("rd_done_pulse", {31'd0, m1_done}, 32'd0);

      // 4) both request continuously, 4 writes each: grants alternate starting with M0
      m0_write = 1'b1; m1_write = 1'b1; m0_request = 1'b1; m1_request = 1'b1;
      grants = 0; exp_m1 = 1'b0;
      for (int c = 0; c < 40 && grants < 8; c++) begin
         tick();
         check("rr_no_double_grant", {31'd0, m0_grant & m1_grant}, 32'd0);
         check("rr_no_double_done", {31'd0, m0_done & m1_done}, 32'd0);
         if (m0_grant || m1_grant) begin
            check("rr_order", {30'd0, m1_grant, m0_grant}, exp_m1 ? 32'b10 : 32'b01);
            exp_m1 = ~exp_m1;
            grants++;
            if (grants == 8) begin
               m0_request = 1'b0; m1_request = 1'b0;
            end
         end
      end
      check("rr_grant_count", grants, 32'd8);
      tick();
      tick();
      check("rr_back_idle", {31'd0, busy}, 32'd0);

      // 5) M1 requests during an M0 read
      slave_data_a = 32'hCAFE_F00D;
      m0_request = 1'b1; m0_write = 1'b0; m0_address = 32'h0000_0020;
      m1_write = 1'b1; m1_address = 32'h0000_0044;
      tick();
      check("ovl_m0_grant", {30'd0, m1_grant, m0_grant}, 32'b01);
      tick();
      m1_request = 1'b1;
      tick();
      check("ovl_wait_no_m1_grant", {31'd0, m1_grant}, 32'd0);
      tick();
      check("ovl_m0_done", {30'd0, m1_done, m0_done}, 32'b01);
      check("ovl_m0_data", m0_data_fetched, 32'hCAFE_F00D);
      m0_request = 1'b0;
      tick();
      check("ovl_idle_gap", {30'd0, busy, m1_grant}, 32'd0);
      tick();
      check("ovl_m1_grant", {30'd0, m1_grant, m0_grant}, 32'b10);
      check("ovl_m1_address", bus_address, 32'h0000_0044);
      m1_request = 1'b0;
      tick();
      check("ovl_m1_done", {30'd0, m1_done, m0_done}, 32'b10);
      check("ovl_m0_data_kept", m0_data_fetched, 32'hCAFE_F00D);
      check("ovl_m1_data_kept", m1_data_fetched, 32'h1234_5678);
      tick();

      // 6a) instance B: full read with READ_LATENCY=4, done at t+6
      slave_data_b = 32'h5A5A_5A5A;
      b_m0_request = 1'b1; b_m0_write = 1'b0; b_m0_address = 32'h0000_0300;
      tick();
      check("b_rd_enable", {30'd0, b_bus_write_enable, b_bus_read_enable}, 32'b01);
      b_m0_request = 1'b0;
      for (int k = 2; k <= 5; k++) begin
         tick();
         check("b_wait_no_done", {31'd0, b_m0_done}, 32'd0);
      end
      tick();
      check("b_rd_done_t6", {31'd0, b_m0_done}, 32'd1);
      check("b_rd_data", b_m0_data_fetched, 32'h5A5A_5A5A);
      tick();

      // 6b) reset asserted during WAIT
      slave_data_b = 32'h0BAD_0BAD;
      b_m0_request = 1'b1; b_m0_address = 32'h0000_0304;
      tick();
      tick();
      tick();
      check("b_busy_in_wait", {31'd0, b_busy}, 32'd1);
      b_reset = 1'b1; b_m0_request = 1'b0;
      tick();
      check("b_rst_enables", {30'd0, b_bus_write_enable, b_bus_read_enable}, 32'd0);
      check("b_rst_busy", {31'd0, b_busy}, 32'd0);
      check("b_rst_address", b_bus_address, 32'd0);
      check("b_rst_all_zero", {31'd0, any_out_b}, 32'd0);
      b_reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("b_no_done_after_abort", {30'd0, b_busy, b_m0_done}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
